tlb_lookup_responder: RTL

- Main joint TLB array; the responder for the instruction- and data-side TLB buffers that issue a VPN2 lookup on a buffer miss.
- Services the fetch port (s0) and the memory port (s1) with a registered one-cycle lookup, so a result is ready in the requester's SEARCH cycle.
- Also executes TLBWI/TLBWR/TLBP/TLBR for CP0 and maintains the Random register.

---
 rtl/tlb_lookup_responder.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/tlb_lookup_responder.sv
// Joint TLB: registered 1-cycle lookups (s0 fetch, s1 data), CP0 TLBWI/TLBWR/TLBP/TLBR, Random counter.
// No backpressure, outputs refresh every cycle; `TLB_MULTIHIT_EN adds s0/s1_multihit duplicate-match flags.
module tlb_lookup_responder #(
  parameter int TLBNUM = 16,
  parameter int IDXW   = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      CP0_ASID,
  input  logic [18:0]     s0_vpn2,
  output logic            s0_found,
  output logic [77:0]     s0_entry,
  input  logic [18:0]     s1_vpn2,
  output logic            s1_found,
  output logic [77:0]     s1_entry,
  input  logic            tlbwi,
  input  logic            tlbwr,
  input  logic [IDXW-1:0] w_index,
  input  logic [77:0]     w_entry,
  input  logic            tlbp,
  input  logic [18:0]     p_vpn2,
  output logic            p_found,
  output logic [IDXW-1:0] p_index,
  output logic [77:0]     r_entry,
  input  logic [IDXW-1:0] wired,
  input  logic            wired_wr,
`ifdef TLB_MULTIHIT_EN
  output logic            s0_multihit,
  output logic            s1_multihit,
`endif
  output logic [IDXW-1:0] random
);

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  localparam logic [IDXW-1:0] RND_MAX = IDXW'(TLBNUM - 1);

  tlb_entry_t tlb_q [TLBNUM];
  tlb_entry_t tlb_d [TLBNUM];

  logic            s0_found_q, s0_found_d;
  logic            s1_found_q, s1_found_d;
  tlb_entry_t      s0_entry_q, s0_entry_d;
  tlb_entry_t      s1_entry_q, s1_entry_d;
  logic            p_found_q, p_found_d;
  logic [IDXW-1:0] p_index_q, p_index_d;
  tlb_entry_t      r_entry_q, r_entry_d;
  logic [IDXW-1:0] random_q, random_d;

  logic [TLBNUM-1:0] s0_match, s1_match, p_match;
  logic [IDXW-1:0]   s0_idx, s1_idx, p_idx;
  logic [IDXW-1:0]   wr_idx;

  function automatic logic [IDXW-1:0] lowest(input logic [TLBNUM-1:0] v);
    logic [IDXW-1:0] r;
    r = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (v[i]) r = IDXW'(i);
    end
    return r;
  endfunction

  always_comb begin
    s0_match = '0;
    s1_match = '0;
    p_match  = '0;
    for (int i = 0; i < TLBNUM; i++) begin
      s0_match[i] = (tlb_q[i].vpn2 == s0_vpn2) && (tlb_q[i].g || tlb_q[i].asid == CP0_ASID);
      s1_match[i] = (tlb_q[i].vpn2 == s1_vpn2) && (tlb_q[i].g || tlb_q[i].asid == CP0_ASID);
      p_match[i]  = (tlb_q[i].vpn2 == p_vpn2)  && (tlb_q[i].g || tlb_q[i].asid == CP0_ASID);
    end
    s0_idx = lowest(s0_match);
    s1_idx = lowest(s1_match);
    p_idx  = lowest(p_match);
  end

  // Lookups read the pre-write array, so a same-cycle write shows up one sample later.
  always_comb begin
    s0_found_d = |s0_match;
    s1_found_d = |s1_match;
    s0_entry_d = s0_found_d ? tlb_q[s0_idx] : '0;
    s1_entry_d = s1_found_d ? tlb_q[s1_idx] : '0;
    r_entry_d  = tlb_q[w_index];
    p_found_d  = p_found_q;
    p_index_d  = p_index_q;
    if (tlbp) begin
      p_found_d = |p_match;
      p_index_d = p_idx;
    end
  end

  always_comb begin
    wr_idx = tlbwi ? w_index : random_q;
    for (int i = 0; i < TLBNUM; i++) begin
      tlb_d[i] = tlb_q[i];
    end
    if (tlbwi || tlbwr) begin
      tlb_d[wr_idx] = tlb_entry_t'(w_entry);
    end
  end

  // Reload when Wired is rewritten, when the wired floor is reached, or when no random slots remain.
  always_comb begin
    random_d = random_q - IDXW'(1);
    if (wired_wr || (wired >= RND_MAX) || (random_q <= wired)) begin
      random_d = RND_MAX;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tlb_q      <= '{default: '0};
      s0_found_q <= 1'b0;
      s1_found_q <= 1'b0;
      s0_entry_q <= '0;
      s1_entry_q <= '0;
      p_found_q  <= 1'b0;
      p_index_q  <= '0;
      r_entry_q  <= '0;
      random_q   <= RND_MAX;
    end else begin
      tlb_q      <= tlb_d;
      s0_found_q <= s0_found_d;
      s1_found_q <= s1_found_d;
      s0_entry_q <= s0_entry_d;
      s1_entry_q <= s1_entry_d;
      p_found_q  <= p_found_d;
      p_index_q  <= p_index_d;
      r_entry_q  <= r_entry_d;
      random_q   <= random_d;
    end
  end

  assign s0_found = s0_found_q;
  assign s1_found = s1_found_q;
  assign s0_entry = s0_entry_q;
  assign s1_entry = s1_entry_q;
  assign p_found  = p_found_q;
  assign p_index  = p_index_q;
  assign r_entry  = r_entry_q;
  assign random   = random_q;

`ifdef TLB_MULTIHIT_EN
  logic s0_multi_q, s0_multi_d;
  logic s1_multi_q, s1_multi_d;

  // Clearing the lowest set bit leaves something only when two or more entries match.
  function automatic logic multi(input logic [TLBNUM-1:0] v);
    return |(v & (v - TLBNUM'(1)));
  endfunction

  always_comb begin
    s0_multi_d = multi(s0_match);
    s1_multi_d = multi(s1_match);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_multi_q <= 1'b0;
      s1_multi_q <= 1'b0;
    end else begin
      s0_multi_q <= s0_multi_d;
      s1_multi_q <= s1_multi_d;
    end
  end

  assign s0_multihit = s0_multi_q;
  assign s1_multihit = s1_multi_q;
`endif

endmodule
